// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: joystick bit map and coin FSM states shared by the input conditioner
package arcade_input_pkg;
  localparam int J_RIGHT  = 0;
  localparam int J_LEFT   = 1;
  localparam int J_DOWN   = 2;
  localparam int J_UP     = 3;
  localparam int J_FIRE   = 4;
  localparam int J_START1 = 5;
  localparam int J_START2 = 6;
  localparam int J_COIN   = 7;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
endpackage

// File: rtl/arcade_coin_pulser.sv
// arcade_coin_pulser: coin edge queue turned into frame-timed pulses with a minimum low gap
module arcade_coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 2,
  parameter int COIN_QUEUE  = 3
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic coin_src,
  input  logic tick,
  output logic coin_out
);
  localparam int PW = $clog2(COIN_QUEUE + 1);
  localparam int CW = $clog2((COIN_FRAMES > COIN_GAP ? COIN_FRAMES : COIN_GAP) + 1);
  coin_state_t state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic coin_prev_q, edge_c, take;
  always_comb begin
    edge_c = coin_src & ~coin_prev_q;
    take = (state_q == IDLE) && (pend_q != '0);
    pend_d = pend_q;
    if (edge_c && !take && pend_q != PW'(COIN_QUEUE)) pend_d = pend_q + 1'b1;
    else if (take && !edge_c) pend_d = pend_q - 1'b1;
    state_d = state_q;
    cnt_d = cnt_q;
    if (take) begin
      state_d = PULSE;
      cnt_d = '0;
    end else if (tick && state_q == PULSE) begin
      if (cnt_q == CW'(COIN_FRAMES - 1)) begin
        state_d = GAP;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
    end else if (tick && state_q == GAP) begin
      if (cnt_q == CW'(COIN_GAP - 1)) begin
        state_d = IDLE;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q <= '0;
      cnt_q <= '0;
      coin_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      coin_prev_q <= coin_src;
    end
  end
  assign coin_out = (state_q == PULSE);
endmodule

// File: rtl/arcade_input_cond.sv
// arcade_input_cond: per-player routing, autofire and queued coin pulses between hps_io and the core
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int JOY_W       = 16,
  parameter int COIN_FRAMES = 3,
  parameter int COIN_GAP    = 2,
  parameter int COIN_QUEUE  = 3,
  parameter int AF_FRAMES   = 2
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [NUM_PLAYERS*JOY_W-1:0] joy_in,
  input  logic                     vblank,
  input  logic                     share_mode,
  input  logic [NUM_PLAYERS-1:0]   autofire_en,
  output logic [NUM_PLAYERS*4-1:0] dir_out,
  output logic [NUM_PLAYERS-1:0]   fire_out,
  output logic                     start1,
  output logic                     start2,
  output logic [NUM_PLAYERS-1:0]   coin_out,
  output logic                     frame_tick
);
  localparam int AW = $clog2(AF_FRAMES + 1);
  logic [JOY_W-1:0] any_pad;
  logic [JOY_W-1:0] src [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] coin_src, fire_q, fire_d, af_on_q, af_on_d;
  logic [AW-1:0] af_cnt_q [NUM_PLAYERS];
  logic [AW-1:0] af_cnt_d [NUM_PLAYERS];
  logic [NUM_PLAYERS*4-1:0] dir_q, dir_d;
  logic start1_q, start1_d, start2_q, start2_d, vblank_q, frame_tick_q, frame_tick_d;
  always_comb begin
    any_pad = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) any_pad = any_pad | joy_in[p*JOY_W +: JOY_W];
    coin_src = '0;
    dir_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      src[p] = share_mode ? any_pad : joy_in[p*JOY_W +: JOY_W];
      // shared coin credits only player 0 so one drop never yields N credits
      coin_src[p] = share_mode ? (p == 0) && any_pad[J_COIN] : src[p][J_COIN];
      dir_d[p*4 +: 4] = {src[p][J_UP], src[p][J_DOWN], src[p][J_LEFT], src[p][J_RIGHT]};
    end
    start1_d = any_pad[J_START1];
    start2_d = any_pad[J_START2];
    frame_tick_d = vblank & ~vblank_q;
  end
  always_comb begin
    fire_d = fire_q;
    af_cnt_d = af_cnt_q;
    af_on_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      af_on_d[p] = src[p][J_FIRE] & autofire_en[p];
      if (!af_on_d[p] || !af_on_q[p]) begin
        fire_d[p] = src[p][J_FIRE];
        af_cnt_d[p] = '0;
      end else if (frame_tick_q) begin
        if (af_cnt_q[p] == AW'(AF_FRAMES - 1)) begin
          fire_d[p] = ~fire_q[p];
          af_cnt_d[p] = '0;
        end else af_cnt_d[p] = af_cnt_q[p] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= '0;
      fire_q <= '0;
      af_on_q <= '0;
      af_cnt_q <= '{default: '0};
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      vblank_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      fire_q <= fire_d;
      af_on_q <= af_on_d;
      af_cnt_q <= af_cnt_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
      vblank_q <= vblank;
      frame_tick_q <= frame_tick_d;
    end
  end
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_coin
    arcade_coin_pulser #(
      .COIN_FRAMES(COIN_FRAMES),
      .COIN_GAP(COIN_GAP),
      .COIN_QUEUE(COIN_QUEUE)
    ) u_pulser (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .coin_src(coin_src[i]),
      .tick(frame_tick_q),
      .coin_out(coin_out[i])
    );
  end
  assign dir_out = dir_q;
  assign fire_out = fire_q;
  assign start1 = start1_q;
  assign start2 = start2_q;
  assign frame_tick = frame_tick_q;
endmodule
